// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator: 640x480@60 defaults,
// sync polarity encodings and helpers to derive the line/frame totals.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic ACTIVE_LOW  = 1'b0;
  localparam logic ACTIVE_HIGH = 1'b1;

  // Pixels per line including blanking.
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Lines per frame including blanking.
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel clock-enable divider: tick is high for one CLK out of every DIV.
// With DIV=1 the counter is pinned at 0 and tick is permanently high.
module vga_pix_div #(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt;

  if (DIV < 1) begin : g_bad_div
    $error("vga_pix_div: DIV must be >= 1");
  end

  assign tick = (div_cnt == LAST);

  // Free-running modulo-DIV counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, horizontal/vertical counters and
// registered sync / active-video / strobe outputs, all updated on the same edge.
// Free-running source with no handshake; consumers qualify work with p_tick.
// Optional feature macro: VTG_FRAME_CNT_EN adds a wrapping frame counter on
// frame_cnt; without it frame_cnt is constant 0 and no register exists.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic H_POL       = ACTIVE_LOW,
  parameter logic V_POL       = ACTIVE_LOW,
  parameter int   DIV         = 4,
  parameter int   CNT_W       = 10,
  parameter int   FRAME_CNT_W = 6
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  output logic                   p_tick,
  output logic                   sincro_horiz,
  output logic                   sincro_vert,
  output logic                   video_on,
  output logic [CNT_W-1:0]       pixel_X,
  output logic [CNT_W-1:0]       pixel_Y,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);

  if (H_TOT > 2 ** CNT_W) begin : g_bad_h
    $error("vga_timing_gen: horizontal total does not fit in CNT_W");
  end
  if (V_TOT > 2 ** CNT_W) begin : g_bad_v
    $error("vga_timing_gen: vertical total does not fit in CNT_W");
  end

  logic             tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             frame_wrap;

  vga_pix_div #(
    .DIV (DIV)
  ) u_div (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .tick    (tick)
  );

  // Position the counters hold after the coming edge; decode is taken from
  // this so every output register lines up with the counter registers.
  always_comb begin
    h_wrap     = (h_cnt == H_LAST);
    v_wrap     = (v_cnt == V_LAST);
    h_next     = h_cnt;
    v_next     = v_cnt;
    frame_wrap = 1'b0;
    if (tick) begin
      h_next = h_wrap ? '0 : h_cnt + CNT_W'(1);
      if (h_wrap) begin
        v_next     = v_wrap ? '0 : v_cnt + CNT_W'(1);
        frame_wrap = v_wrap;
      end
    end
  end

  // Counters and registered decode of the next position.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      p_tick       <= 1'b0;
      sincro_horiz <= ~H_POL;
      sincro_vert  <= ~V_POL;
      video_on     <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      h_cnt        <= h_next;
      v_cnt        <= v_next;
      p_tick       <= tick;
      sincro_horiz <= (int'(h_next) >= HS_FIRST && int'(h_next) <= HS_LAST) ? H_POL : ~H_POL;
      sincro_vert  <= (int'(v_next) >= VS_FIRST && int'(v_next) <= VS_LAST) ? V_POL : ~V_POL;
      video_on     <= (int'(h_next) < H_ACTIVE) && (int'(v_next) < V_ACTIVE);
      line_start   <= tick && h_wrap;
      frame_start  <= frame_wrap;
    end
  end

  assign pixel_X = h_cnt;
  assign pixel_Y = v_cnt;

`ifdef VTG_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_q;

  // Frame counter steps on the same edge that raises frame_start.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_q <= '0;
    end else if (frame_wrap) begin
      frame_q <= frame_q + FRAME_CNT_W'(1);
    end
  end

  assign frame_cnt = frame_q;
`else
  assign frame_cnt = '0;
`endif

endmodule
